// File: rtl/lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
// Size/state enums plus byte-enable and store-lane helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  typedef logic [3:0] be_t;

  // Encoding 2'b11 is folded onto word access.
  function automatic size_e to_size(
    input logic [1:0] i_enc
  );
    size_e v;
    unique case (i_enc)
      2'b00:   v = SZ_BYTE;
      2'b01:   v = SZ_HALF;
      default: v = SZ_WORD;
    endcase
    return v;
  endfunction

  function automatic logic misaligned(
    input size_e      i_sz,
    input logic [1:0] i_off
  );
    logic m;
    unique case (i_sz)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = i_off[0];
      default: m = |i_off;
    endcase
    return m;
  endfunction

  function automatic be_t gen_be(
    input size_e      i_sz,
    input logic [1:0] i_off
  );
    be_t be;
    unique case (i_sz)
      SZ_BYTE: be = 4'b0001 << i_off;
      SZ_HALF: be = 4'b0011 << {i_off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] gen_wdata(
    input size_e       i_sz,
    input logic [31:0] i_wd
  );
    logic [31:0] w;
    unique case (i_sz)
      SZ_BYTE: w = {4{i_wd[7:0]}};
      SZ_HALF: w = {2{i_wd[15:0]}};
      default: w = i_wd;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane extraction: shift the addressed lane down,
// then sign- or zero-extend to 32 bits by access size.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  size_e       i_size,
  input  logic        i_uns,
  output logic [31:0] o_data
);

  logic [31:0] w_lane;
  logic        w_sb;
  logic        w_sh;

  assign w_lane = i_rdata >> {i_off, 3'b000};
  assign w_sb   = ~i_uns & w_lane[7];
  assign w_sh   = ~i_uns & w_lane[15];

  always_comb begin
    o_data = w_lane;
    unique case (i_size)
      SZ_BYTE: o_data = {{24{w_sb}}, w_lane[7:0]};
      SZ_HALF: o_data = {{16{w_sh}}, w_lane[15:0]};
      default: o_data = w_lane;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit driving a single-outstanding
// valid/ready data bus; stalls the pipe while busy.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemReadM,
  input  logic          MemWriteM,
  input  logic [1:0]    ByteAccessM,
  input  logic          LoadUnsignedM,
  input  logic [AW-1:0] ALUResultM,
  input  logic [DW-1:0] WriteDataM,
  output logic          StallM,
  output logic [DW-1:0] ReadDataM,
  output logic          MisalignM,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  state_e        r_state;
  state_e        w_next;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_off;
  be_t           r_be;
  logic [DW-1:0] r_wdata;
  logic          r_we;
  size_e         r_size;
  logic          r_uns;
  logic [DW-1:0] r_rdata;

  size_e         w_size;
  logic [1:0]    w_off;
  logic          w_access;
  logic          w_mis;
  logic          w_start;
  logic          w_capture;
  logic [DW-1:0] w_ld;

  assign w_size   = to_size(ByteAccessM);
  assign w_off    = ALUResultM[1:0];
  assign w_access = MemReadM | MemWriteM;
  assign w_mis    = misaligned(w_size, w_off);

  always_comb begin
    w_next    = r_state;
    StallM    = 1'b0;
    MisalignM = 1'b0;
    w_start   = 1'b0;
    w_capture = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_access && w_mis) begin
          MisalignM = 1'b1;
        end else if (w_access) begin
          StallM  = 1'b1;
          w_start = 1'b1;
          w_next  = REQ;
        end
      end
      REQ: begin
        StallM = 1'b1;
        if (mem_gnt) w_next = r_we ? DONE : WAIT;
      end
      WAIT: begin
        StallM = 1'b1;
        if (mem_rvalid) begin
          w_capture = 1'b1;
          w_next    = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Store wins when both read and write are flagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_off   <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_size  <= SZ_WORD;
      r_uns   <= 1'b0;
    end else if (w_start) begin
      r_addr  <= {ALUResultM[AW-1:2], 2'b00};
      r_off   <= w_off;
      r_be    <= gen_be(w_size, w_off);
      r_wdata <= gen_wdata(w_size, WriteDataM);
      r_we    <= MemWriteM;
      r_size  <= w_size;
      r_uns   <= LoadUnsignedM;
    end
  end

  lsu_load_align u_align (
    .i_rdata (mem_rdata),
    .i_off   (r_off),
    .i_size  (r_size),
    .i_uns   (r_uns),
    .o_data  (w_ld)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_rdata <= '0;
    else if (w_capture) r_rdata <= w_ld;
  end

  assign mem_req   = (r_state == REQ);
  assign mem_we    = mem_req & r_we;
  assign mem_addr  = r_addr;
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;
  assign ReadDataM = r_rdata;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases plus
// randomized transactions against a byte-lane reference model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [1:0]  ByteAccessM = 2'b00;
  logic        LoadUnsignedM = 1'b0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        MisalignM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd = '0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.AW(32), .DW(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .MemReadM      (MemReadM),
    .MemWriteM     (MemWriteM),
    .ByteAccessM   (ByteAccessM),
    .LoadUnsignedM (LoadUnsignedM),
    .ALUResultM    (ALUResultM),
    .WriteDataM    (WriteDataM),
    .StallM        (StallM),
    .ReadDataM     (ReadDataM),
    .MisalignM     (MisalignM),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz,
                                        input logic [31:0] a);
    logic [3:0] be = '0;
    int n = nbytes(sz);
    int off = int'(a[1:0]);
    for (int b = 0; b < 4; b++)
      if (b >= off && b < off + n) be[b] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] ref_wd(input logic [1:0] sz,
                                         input logic [31:0] wd);
    logic [31:0] w = '0;
    int n = nbytes(sz);
    for (int b = 0; b < 4; b++)
      w[8*b +: 8] = wd[8*(b % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_ld(input logic [1:0] sz,
                                         input logic uns,
                                         input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] v = '0;
    logic [31:0] mask;
    int n = nbytes(sz);
    int off = int'(a[1:0]);
    for (int k = 0; k < n; k++)
      v[8*k +: 8] = rd[8*(off+k) +: 8];
    if (n < 4 && !uns && v[8*n-1]) begin
      mask = (32'd1 << (8*n)) - 32'd1;
      v = v | ~mask;
    end
    return v;
  endfunction

  task automatic run_txn(
    input  logic        re,
    input  logic        we,
    input  logic [1:0]  sz,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic [31:0] rd,
    input  int          gdly,
    input  int          rdly,
    input  logic        spur,
    output int          stalls,
    output int          reqs,
    output int          grants,
    output logic        unstable,
    output logic        done_seen,
    output logic [31:0] o_a,
    output logic [3:0]  o_be,
    output logic [31:0] o_w,
    output logic        o_we,
    output logic [31:0] rd_done,
    output logic        rd_moved
  );
    int waits = 0;
    logic granted = 1'b0;
    logic [31:0] rd0;
    stalls = 0; reqs = 0; grants = 0;
    unstable = 0; done_seen = 0; rd_moved = 0;
    o_a = '0; o_be = '0; o_w = '0; o_we = 0; rd_done = '0;
    @(negedge clk);
    MemReadM = re; MemWriteM = we; ByteAccessM = sz;
    LoadUnsignedM = uns; ALUResultM = addr; WriteDataM = wd;
    mem_gnt = 0; mem_rvalid = 0;
    rd0 = ReadDataM;
    for (int c = 0; c < 60 && !done_seen; c++) begin
      #1;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
      if (StallM) stalls++;
      if (c > 0 && !StallM) begin
        done_seen = 1;
        rd_done = ReadDataM;
      end else if (ReadDataM !== rd0) begin
        rd_moved = 1;
      end
      if (mem_req) begin
        reqs++;
        if (reqs == 1) begin
          o_a = mem_addr; o_be = mem_be; o_w = mem_wdata; o_we = mem_we;
        end else if (mem_addr !== o_a || mem_be !== o_be ||
                     mem_wdata !== o_w || mem_we !== o_we) begin
          unstable = 1;
        end
        if (spur) begin
          mem_rvalid = 1; mem_rdata = ~rd;
        end
        if (reqs > gdly) begin
          mem_gnt = 1; granted = 1; grants++;
        end
      end else if (granted && !we && !done_seen) begin
        waits++;
        if (waits > rdly) begin
          mem_rvalid = 1; mem_rdata = rd;
        end
      end
      @(negedge clk);
    end
    MemReadM = 0; MemWriteM = 0;
    mem_gnt = 0; mem_rvalid = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (StallM !== 0 || mem_req !== 0 || mem_we !== 0 || MisalignM !== 0) begin
      errors++;
      $display("FAIL reset_ctrl got stall=%b req=%b we=%b mis=%b want 0000",
               StallM, mem_req, mem_we, MisalignM);
    end
    checks++;
    if (mem_addr !== 0 || mem_be !== 0 || mem_wdata !== 0 || ReadDataM !== 0) begin
      errors++;
      $display("FAIL reset_data got a=%h be=%b w=%h rd=%h want zeros",
               mem_addr, mem_be, mem_wdata, ReadDataM);
    end
    @(negedge clk);
    reset = 1;
    last_rd = '0;
  endtask

  task automatic test_store_byte();
    int st, rq, gr; logic un, dn, wv, mv; logic [31:0] a, w, r; logic [3:0] be;
    run_txn(0, 1, 2'b00, 0, 32'h103, 32'h0000_00AB, 0, 0, 0, 0,
            st, rq, gr, un, dn, a, be, w, wv, r, mv);
    checks++;
    if (!dn || st != 2 || gr != 1) begin
      errors++;
      $display("FAIL store_byte_timing got done=%b stall=%0d gnt=%0d want 1 2 1",
               dn, st, gr);
    end
    checks++;
    if (a !== 32'h100 || be !== 4'b1000 || w !== 32'hABAB_ABAB || wv !== 1) begin
      errors++;
      $display("FAIL store_byte_bus got a=%h be=%b w=%h we=%b want 100 1000 abababab 1",
               a, be, w, wv);
    end
    checks++;
    if (r !== last_rd) begin
      errors++;
      $display("FAIL store_byte_rd got %h want %h", r, last_rd);
    end
  endtask

  task automatic test_load_half();
    int st, rq, gr; logic un, dn, wv, mv; logic [31:0] a, w, r; logic [3:0] be;
    for (int u = 0; u < 2; u++) begin
      run_txn(1, 0, 2'b01, u[0], 32'h202, '0, 32'h8001_1234, 0, 0, 0,
              st, rq, gr, un, dn, a, be, w, wv, r, mv);
      checks++;
      if (!dn || st != 3 || a !== 32'h200 || be !== 4'b1100 || wv !== 0) begin
        errors++;
        $display("FAIL load_half_bus u=%0d got done=%b stall=%0d a=%h be=%b we=%b",
                 u, dn, st, a, be, wv);
      end
      checks++;
      if (r !== (u == 0 ? 32'hFFFF_8001 : 32'h0000_8001)) begin
        errors++;
        $display("FAIL load_half_data u=%0d got %h want %h", u, r,
                 (u == 0 ? 32'hFFFF_8001 : 32'h0000_8001));
      end
      last_rd = r;
    end
  endtask

  task automatic test_load_byte_word();
    int st, rq, gr; logic un, dn, wv, mv; logic [31:0] a, w, r; logic [3:0] be;
    run_txn(1, 0, 2'b00, 1, 32'h1, '0, 32'h0000_F000, 0, 0, 0,
            st, rq, gr, un, dn, a, be, w, wv, r, mv);
    checks++;
    if (!dn || r !== 32'h0000_00F0 || be !== 4'b0010) begin
      errors++;
      $display("FAIL load_byte_u got done=%b rd=%h be=%b want 1 000000f0 0010",
               dn, r, be);
    end
    run_txn(1, 0, 2'b10, 0, 32'h4, '0, 32'hDEAD_BEEF, 0, 1, 0,
            st, rq, gr, un, dn, a, be, w, wv, r, mv);
    checks++;
    if (!dn || r !== 32'hDEAD_BEEF || a !== 32'h4 || st != 4) begin
      errors++;
      $display("FAIL load_word got done=%b rd=%h a=%h stall=%0d want 1 deadbeef 4 4",
               dn, r, a, st);
    end
    last_rd = r;
  endtask

  task automatic test_backpressure();
    int st, rq, gr; logic un, dn, wv, mv; logic [31:0] a, w, r; logic [3:0] be;
    run_txn(0, 1, 2'b01, 0, 32'h3A2, 32'h1234_5678, '0, 3, 0, 1,
            st, rq, gr, un, dn, a, be, w, wv, r, mv);
    checks++;
    if (!dn || un || rq != 4 || gr != 1 || st != 5) begin
      errors++;
      $display("FAIL backpressure got done=%b unstable=%b req=%0d gnt=%0d stall=%0d want 1 0 4 1 5",
               dn, un, rq, gr, st);
    end
    checks++;
    if (a !== 32'h3A0 || be !== 4'b1100 || w !== 32'h5678_5678) begin
      errors++;
      $display("FAIL backpressure_bus got a=%h be=%b w=%h want 3a0 1100 56785678",
               a, be, w);
    end
  endtask

  task automatic test_misalign();
    logic [1:0]  szs [2] = '{2'b10, 2'b01};
    logic [31:0] ads [2] = '{32'h6, 32'h11};
    logic any_req;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      MemReadM = (i == 0); MemWriteM = (i == 1);
      ByteAccessM = szs[i]; ALUResultM = ads[i]; WriteDataM = 32'hCAFE_F00D;
      #1;
      checks++;
      if (MisalignM !== 1 || StallM !== 0 || mem_req !== 0) begin
        errors++;
        $display("FAIL misalign_flag i=%0d got mis=%b stall=%b req=%b want 1 0 0",
                 i, MisalignM, StallM, mem_req);
      end
      @(negedge clk);
      MemReadM = 0; MemWriteM = 0;
      any_req = 0;
      for (int c = 0; c < 3; c++) begin
        #1;
        if (mem_req || MisalignM || StallM) any_req = 1;
        @(negedge clk);
      end
      checks++;
      if (any_req !== 0) begin
        errors++;
        $display("FAIL misalign_after i=%0d got activity=%b want 0", i, any_req);
      end
    end
  endtask

  task automatic test_random();
    int st, rq, gr; logic un, dn, wv, mv; logic [31:0] a, w, r; logic [3:0] be;
    logic re, we, uns, spur; logic [1:0] sz; logic [31:0] addr, wd, rd;
    int gd, rdl, kind, n, est;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      re = (kind != 1); we = (kind != 0);
      sz = 2'($urandom_range(0, 3));
      n = nbytes(sz);
      addr = $urandom & ~32'(n - 1);
      wd = $urandom; rd = $urandom;
      uns = 1'($urandom); spur = 1'($urandom);
      gd = $urandom_range(0, 3); rdl = $urandom_range(0, 2);
      run_txn(re, we, sz, uns, addr, wd, rd, gd, rdl, spur,
              st, rq, gr, un, dn, a, be, w, wv, r, mv);
      est = we ? 2 + gd : 3 + gd + rdl;
      checks++;
      if (!dn || st != est || gr != 1 || rq != gd + 1 || un) begin
        errors++;
        $display("FAIL rand_timing i=%0d got done=%b stall=%0d gnt=%0d req=%0d unst=%b want stall=%0d",
                 i, dn, st, gr, rq, un, est);
      end
      checks++;
      if (a !== {addr[31:2], 2'b00} || be !== ref_be(sz, addr) || wv !== we) begin
        errors++;
        $display("FAIL rand_bus i=%0d got a=%h be=%b we=%b want %h %b %b",
                 i, a, be, wv, {addr[31:2], 2'b00}, ref_be(sz, addr), we);
      end
      if (we) begin
        checks++;
        if (w !== ref_wd(sz, wd) || r !== last_rd || mv) begin
          errors++;
          $display("FAIL rand_store i=%0d got w=%h rd=%h moved=%b want %h %h",
                   i, w, r, mv, ref_wd(sz, wd), last_rd);
        end
      end else begin
        checks++;
        if (r !== ref_ld(sz, uns, addr, rd) || mv) begin
          errors++;
          $display("FAIL rand_load i=%0d got rd=%h moved=%b want %h",
                   i, r, mv, ref_ld(sz, uns, addr, rd));
        end
        last_rd = ref_ld(sz, uns, addr, rd);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic bad;
    @(negedge clk);
    MemReadM = 1; MemWriteM = 0; ByteAccessM = 2'b10;
    ALUResultM = 32'h40; LoadUnsignedM = 0;
    @(negedge clk);
    #1;
    mem_gnt = mem_req;
    @(negedge clk);
    mem_gnt = 0;
    #1;
    checks++;
    if (StallM !== 1 || mem_req !== 0) begin
      errors++;
      $display("FAIL rst_wait_pre got stall=%b req=%b want 1 0", StallM, mem_req);
    end
    reset = 0;
    MemReadM = 0;
    #1;
    checks++;
    if (StallM !== 0 || mem_req !== 0 || ReadDataM !== 0) begin
      errors++;
      $display("FAIL rst_wait_now got stall=%b req=%b rd=%h want 0 0 0",
               StallM, mem_req, ReadDataM);
    end
    @(negedge clk);
    reset = 1;
    last_rd = '0;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_rvalid = 1; mem_rdata = 32'h1234_5678;
      #1;
      if (ReadDataM !== 0 || StallM !== 0 || mem_req !== 0) bad = 1;
    end
    @(negedge clk);
    mem_rvalid = 0;
    #1;
    checks++;
    if (bad || ReadDataM !== 0) begin
      errors++;
      $display("FAIL rst_wait_after got bad=%b rd=%h want 0 0", bad, ReadDataM);
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_half();
    test_load_byte_word();
    test_backpressure();
    test_misalign();
    test_random();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-stage load/store unit that consumes the M-stage control bundle (MemWriteM, ByteAccessM, load sign control, ALUResultM address, WriteDataM). It drives a single-outstanding valid/ready data-memory bus.
- Store side: generates byte enables and lane-replicated write data.
- Load side: extracts and extends the returned lane into ReadDataM.
- Stalls the pipeline while a bus transaction is in flight.

Parameters:
- AW, 32, address width
- DW, 32, data width (fixed 32; other values unsupported)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- MemReadM  in  1  load in M stage
- MemWriteM  in  1  store in M stage
- ByteAccessM  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- LoadUnsignedM  in  1  1 = zero-extend load, 0 = sign-extend
- ALUResultM  in  AW  byte address
- WriteDataM  in  DW  store data, right-aligned
- StallM  out  1  hold F/D/E/M pipeline registers
- ReadDataM  out  DW  extended load result, valid in DONE
- MisalignM  out  1  misaligned-access exception pulse
- mem_req  out  1  bus request valid
- mem_we  out  1  bus write
- mem_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  DW  lane-replicated store data
- mem_gnt  in  1  bus accepts request when mem_req&mem_gnt
- mem_rvalid  in  1  read data valid (loads only)
- mem_rdata  in  DW  read data

Behaviour:
- Reset (reset=0, async): state=IDLE; StallM, mem_req, mem_we, MisalignM = 0; mem_addr, mem_be, mem_wdata, ReadDataM = 0.
- access = MemReadM|MemWriteM. If both are set, the store wins.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0. Flagged combinationally in IDLE:
  - MisalignM=1 that cycle; no bus request; StallM=0.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- Write data:
  - byte: {4{wd[7:0]}}
  - half: {2{wd[15:0]}}
  - word: wd
- Load data: lane = mem_rdata >> (8*addr[1:0]). Take 8, 16 or 32 bits of lane per size; sign- or zero-extend per LoadUnsignedM.
- FSM:
  - IDLE:
    - On aligned access: StallM=1 (combinational); register addr, be, wdata, we, size, unsigned; go to REQ.
    - Otherwise StallM=0.
  - REQ: mem_req=1 with registered fields; StallM=1. On mem_gnt, go to DONE if write, WAIT if read. Without gnt, hold with all bus fields stable.
  - WAIT: StallM=1. On mem_rvalid, register the extended data into ReadDataM and go to DONE. mem_rvalid in the same cycle as gnt is not accepted (response earliest one cycle after gnt).
  - DONE: StallM=0; ReadDataM held; unconditionally go to IDLE. The pipeline advances on this edge, so IDLE sees the next instruction and the completed access is never reissued.
- Latency (gnt immediate, rvalid one cycle later):
  - store: StallM high 2 cycles
  - load: StallM high 3 cycles
- ReadDataM holds its last value outside DONE.
- mem_rvalid in IDLE/REQ/DONE is ignored.
- Reset mid-transaction: immediate IDLE, mem_req drops. The memory side shares the same reset, so no orphan response.

Decomposition:
- Shared package lsu_pkg:
  - size enum (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10)
  - FSM state enum (IDLE, REQ, WAIT, DONE)
  - 4-bit byte-enable type
- One sub-module, lsu_load_align: purely combinational lane shift plus sign/zero extend (rdata, addr[1:0], size, unsigned -> 32-bit result). Reusable by a future cache.

Test Plan:
- Store byte: MemWriteM=1, size 00, addr 0x103, wd 0xAB, gnt immediate -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x100, StallM high exactly 2 cycles.
- Load half signed: addr 0x202, rdata 0x8001_1234 on rvalid -> ReadDataM=0xFFFF8001 in DONE. Repeat with LoadUnsignedM=1 -> 0x00008001.
- Load byte unsigned: addr 0x1, rdata 0x00_00_F0_00 -> ReadDataM=0x000000F0. Word load, addr 0x4, rdata 0xDEADBEEF -> 0xDEADBEEF.
- Backpressure: gnt held low 3 cycles -> mem_req/mem_addr/mem_be/mem_wdata stable; StallM high throughout; a single transaction issued.
- Misaligned word: addr 0x6 -> MisalignM=1 for 1 cycle, mem_req never asserted, StallM=0.
- Reset mid-WAIT: reset low -> StallM=0, mem_req=0, state IDLE. A later rvalid after reset release does not change ReadDataM.
